clock_mode_ctrl: RTL and testbench

Front-end control stage that sits directly upstream of the seconds/minutes/hours modulo counter block and drives its control inputs. It synchronises and debounces three push-buttons (mode, up, down) and divides the system clock into a 1 Hz tick. A run/adjust FSM then produces enable_seconds, adjust_enable_minutes, adjust_enable_hours and Up_down. It also provides a blink flag for the display stage.

---
 rtl/clock_mode_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_mode_ctrl
// Purpose  : Control front end for the seconds/minutes/hours counter block.
//            It synchronises and debounces the mode/up/down buttons and turns
//            clean presses into single-cycle pulses. It also divides clk down
//            to a 1 s tick. A RUN -> ADJ_HOUR -> ADJ_MIN -> RUN state machine
//            drives the counter enables, the count direction and a blink flag
//            for the display.
// Ports    : clk                    system clock, rising edge
//            rst                    asynchronous reset, active low
//            btn_mode/up/down       raw asynchronous buttons, active high
//            enable_seconds         1-cycle pulse per second (RUN only)
//            adjust_enable_minutes  1-cycle minute step (ADJ_MIN only)
//            adjust_enable_hours    1-cycle hour step (ADJ_HOUR only)
//            Up_down                count direction, 1 = up, 0 = down
//            mode_state             00 RUN, 01 ADJ_HOUR, 10 ADJ_MIN
//            blink                  display blink flag
// Options  : AUTO_REPEAT_EN - when defined, holding up/down in an adjust
//            state repeats the step after REPEAT_DLY cycles and then every
//            REPEAT_PER cycles.
// Revision : 1.0 - initial release
// ============================================================================
module clock_mode_ctrl #(
  parameter int TICK_DIV     = 100000000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SYNC_STAGES  = 2,
  parameter int BLINK_DIV    = 50000000,
  parameter int REPEAT_DLY   = 50000000,
  parameter int REPEAT_PER   = 20000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       enable_seconds,
  output logic       adjust_enable_minutes,
  output logic       adjust_enable_hours,
  output logic       Up_down,
  output logic [1:0] mode_state,
  output logic       blink
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  if (TICK_DIV < 2 || DEBOUNCE_CYC < 1 || SYNC_STAGES < 2 || BLINK_DIV < 1 ||
      REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_check
    $error("clock_mode_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    ADJ_HOUR = 2'b01,
    ADJ_MIN  = 2'b10
  } state_t;

  state_t state;

  // Button order: 0 = mode, 1 = up, 2 = down
  logic [2:0] raw_btn;
  logic [2:0] press;

  assign raw_btn = {btn_down, btn_up, btn_mode};

  // --------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and press edge detector
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync;
    logic [DB_W-1:0]        db_cnt;
    logic                   deb_lvl;
    logic                   deb_dly;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync    <= '0;
        db_cnt  <= '0;
        deb_lvl <= 1'b0;
        deb_dly <= 1'b0;
      end else begin
        sync    <= {sync[SYNC_STAGES-2:0], raw_btn[b]};
        deb_dly <= deb_lvl;
        // Count consecutive disagreeing samples; any agreeing one restarts.
        if (sync[SYNC_STAGES-1] == deb_lvl) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
          deb_lvl <= ~deb_lvl;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    // Only the rising edge of the clean level is a press; releases are silent.
    assign press[b] = deb_lvl & ~deb_dly;
  end

  logic p_mode;
  logic p_up;
  logic p_down;
  logic single_press;
  logic rep_fire;
  logic rep_dir;
  logic step_req;
  logic step_dir;

  assign p_mode       = press[0];
  assign p_up         = press[1];
  assign p_down       = press[2];
  // Up and down pressed together cancel each other.
  assign single_press = p_up ^ p_down;
  assign step_req     = single_press | rep_fire;
  assign step_dir     = single_press ? p_up : rep_dir;

  // --------------------------------------------------------------------------
  // Optional auto-repeat while up or down stays held in an adjust state
  // --------------------------------------------------------------------------
`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  logic             rep_active;
  logic             rep_first;
  logic [REP_W-1:0] rep_cnt;
  logic             rep_hold;
  logic             rep_at_limit;

  // Holding stops counting if the button is released or both are held.
  assign rep_hold = rep_dir ? (g_btn[1].deb_lvl & ~g_btn[2].deb_lvl)
                            : (g_btn[2].deb_lvl & ~g_btn[1].deb_lvl);
  assign rep_at_limit = rep_first ? (rep_cnt == REP_W'(REPEAT_DLY - 1))
                                  : (rep_cnt == REP_W'(REPEAT_PER - 1));
  assign rep_fire = rep_active & rep_hold & ~p_mode & rep_at_limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_active <= 1'b0;
      rep_first  <= 1'b1;
      rep_dir    <= 1'b1;
      rep_cnt    <= '0;
    end else if (state != RUN && !p_mode && single_press) begin
      rep_active <= 1'b1;
      rep_first  <= 1'b1;
      rep_dir    <= p_up;
      rep_cnt    <= '0;
    end else if (rep_active) begin
      if (p_mode || !rep_hold) begin
        rep_active <= 1'b0;
      end else if (rep_at_limit) begin
        rep_first <= 1'b0;
        rep_cnt   <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
  assign rep_dir  = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Mode FSM with tick divider, blink divider and registered outputs
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0]  tick_cnt;
  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= RUN;
      tick_cnt              <= '0;
      blink_cnt             <= '0;
      enable_seconds        <= 1'b0;
      adjust_enable_minutes <= 1'b0;
      adjust_enable_hours   <= 1'b0;
      Up_down               <= 1'b1;
      blink                 <= 1'b0;
    end else begin
      enable_seconds        <= 1'b0;
      adjust_enable_minutes <= 1'b0;
      adjust_enable_hours   <= 1'b0;
      // The tick counter only runs in RUN; it sits at 0 everywhere else so
      // every RUN entry sees a full TICK_DIV period before the first tick.
      tick_cnt              <= '0;
      case (state)
        RUN: begin
          if (p_mode) begin
            state     <= ADJ_HOUR;
            blink     <= 1'b1;
            blink_cnt <= '0;
          end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
            enable_seconds <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ADJ_HOUR, ADJ_MIN: begin
          if (p_mode) begin
            // Mode wins over a simultaneous up/down press.
            state     <= (state == ADJ_HOUR) ? ADJ_MIN : RUN;
            blink     <= (state == ADJ_HOUR);
            blink_cnt <= '0;
            if (state == ADJ_MIN) begin
              Up_down <= 1'b1;
            end
          end else begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
              blink     <= ~blink;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
            if (step_req) begin
              Up_down <= step_dir;
              if (state == ADJ_HOUR) begin
                adjust_enable_hours <= 1'b1;
              end else begin
                adjust_enable_minutes <= 1'b1;
              end
            end
          end
        end
        default: begin
          state     <= RUN;
          blink     <= 1'b0;
          blink_cnt <= '0;
          Up_down   <= 1'b1;
        end
      endcase
    end
  end

  assign mode_state = state;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_mode_ctrl
// Purpose  : Self-checking bench for clock_mode_ctrl. Directed button
//            sequences plus randomised hold patterns are compared every cycle
//            against a behavioural model. The model describes debouncing as
//            a sample window and timing as elapsed cycles since each mode
//            entry.
// Ports    : none
// Options  : AUTO_REPEAT_EN - the model follows the repeat behaviour too.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_mode_ctrl;

  localparam int TICK_DIV     = 10;
  localparam int DEBOUNCE_CYC = 4;
  localparam int SYNC_STAGES  = 2;
  localparam int BLINK_DIV    = 8;
  localparam int REPEAT_DLY   = 12;
  localparam int REPEAT_PER   = 6;
  localparam int H            = SYNC_STAGES + DEBOUNCE_CYC;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       enable_seconds;
  logic       adjust_enable_minutes;
  logic       adjust_enable_hours;
  logic       Up_down;
  logic [1:0] mode_state;
  logic       blink;

  clock_mode_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .SYNC_STAGES (SYNC_STAGES),
    .BLINK_DIV   (BLINK_DIV),
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_PER  (REPEAT_PER)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .btn_mode             (btn_mode),
    .btn_up               (btn_up),
    .btn_down             (btn_down),
    .enable_seconds       (enable_seconds),
    .adjust_enable_minutes(adjust_enable_minutes),
    .adjust_enable_hours  (adjust_enable_hours),
    .Up_down              (Up_down),
    .mode_state           (mode_state),
    .blink                (blink)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[b][i] is the raw level sampled i edges ago (0 = this edge).
  bit hist [3][H];
  bit m_deb [3];
  bit m_deb_old [3];
  int m_mode;     // 0 RUN, 1 ADJ_HOUR, 2 ADJ_MIN
  int run_age;    // edges spent in RUN since entry
  int adj_age;    // edges spent in the current adjust state since entry
  int rep_age;    // edges held since the last accepted up/down press
  bit rep_on;
  bit rep_dir;
  bit e_sec, e_min, e_hour, e_ud, e_blink;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_deb[b]     = 1'b0;
      m_deb_old[b] = 1'b0;
      for (int i = 0; i < H; i++) hist[b][i] = 1'b0;
    end
    m_mode  = 0;
    run_age = 0;
    adj_age = 0;
    rep_age = 0;
    rep_on  = 1'b0;
    rep_dir = 1'b1;
    e_sec   = 1'b0;
    e_min   = 1'b0;
    e_hour  = 1'b0;
    e_ud    = 1'b1;
    e_blink = 1'b0;
  endtask

  task automatic emit_step(input bit dir);
    e_ud = dir;
    if (m_mode == 1) e_hour = 1'b1;
    else e_min = 1'b1;
  endtask

  // Advance the model by one rising clock edge with the given inputs.
  task automatic model_step(input bit r, input bit m, input bit u, input bit d);
    bit raw [3];
    bit pr [3];
    bit held_up, held_dn, all_diff, hold_ok;
    if (!r) begin
      model_reset();
      return;
    end
    raw = '{m, u, d};
    held_up = m_deb[1];
    held_dn = m_deb[2];
    for (int b = 0; b < 3; b++) begin
      pr[b] = m_deb[b] && !m_deb_old[b];
      for (int i = H - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
      hist[b][0] = raw[b];
      // Level flips once the last DEBOUNCE_CYC synchronised samples all disagree.
      all_diff = 1'b1;
      for (int i = SYNC_STAGES; i < H; i++)
        if (hist[b][i] == m_deb[b]) all_diff = 1'b0;
      m_deb_old[b] = m_deb[b];
      if (all_diff) m_deb[b] = !m_deb[b];
    end

    e_sec  = 1'b0;
    e_min  = 1'b0;
    e_hour = 1'b0;
    if (m_mode == 0) begin
      if (pr[0]) begin
        m_mode  = 1;
        adj_age = 0;
      end else begin
        run_age++;
        if (run_age % TICK_DIV == 0) e_sec = 1'b1;
      end
    end else begin
      if (pr[0]) begin
        m_mode  = (m_mode == 1) ? 2 : 0;
        adj_age = 0;
        rep_on  = 1'b0;
        if (m_mode == 0) begin
          e_ud    = 1'b1;
          run_age = 0;
        end
      end else begin
        adj_age++;
        if (pr[1] != pr[2]) begin
          emit_step(pr[1]);
          rep_on  = 1'b1;
          rep_dir = pr[1];
          rep_age = 0;
        end else if (rep_on) begin
          hold_ok = rep_dir ? (held_up && !held_dn) : (held_dn && !held_up);
          if (!hold_ok) begin
            rep_on = 1'b0;
          end else begin
            rep_age++;
`ifdef AUTO_REPEAT_EN
            if (rep_age == REPEAT_DLY ||
                (rep_age > REPEAT_DLY && (rep_age - REPEAT_DLY) % REPEAT_PER == 0))
              emit_step(rep_dir);
`endif
          end
        end
      end
    end
    e_blink = (m_mode != 0) && ((adj_age / BLINK_DIV) % 2 == 0);
  endtask

  task automatic compare_all();
    check("enable_seconds", enable_seconds, e_sec);
    check("adjust_enable_minutes", adjust_enable_minutes, e_min);
    check("adjust_enable_hours", adjust_enable_hours, e_hour);
    check("Up_down", Up_down, e_ud);
    check("mode_state", mode_state, 8'(m_mode));
    check("blink", blink, e_blink);
    check("pulse_exclusive",
          8'(int'(enable_seconds) + int'(adjust_enable_minutes) + int'(adjust_enable_hours) <= 1),
          8'd1);
  endtask

  // One cycle: compare at the falling edge, then drive the next inputs.
  task automatic cyc(input bit r, input bit m, input bit u, input bit d);
    @(negedge clk);
    compare_all();
    rst      = r;
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    model_step(r, m, u, d);
  endtask

  task automatic seg(input bit m, input bit u, input bit d, input int n);
    repeat (n) cyc(1'b1, m, u, d);
  endtask

  task automatic press_mode();
    seg(1'b1, 1'b0, 1'b0, 8);
    seg(1'b0, 1'b0, 1'b0, 8);
  endtask

  initial begin
    bit seen;
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Idle RUN: ticks every TICK_DIV cycles
    seg(1'b0, 1'b0, 1'b0, 25);
    // Glitch on mode, then a real hold into ADJ_HOUR and blink activity
    seg(1'b1, 1'b0, 1'b0, 3);
    seg(1'b0, 1'b0, 1'b0, 6);
    seg(1'b1, 1'b0, 1'b0, 20);
    seg(1'b0, 1'b0, 1'b0, 20);
    // Three up steps and one down step
    repeat (3) begin
      seg(1'b0, 1'b1, 1'b0, 8);
      seg(1'b0, 1'b0, 1'b0, 8);
    end
    seg(1'b0, 1'b0, 1'b1, 8);
    seg(1'b0, 1'b0, 1'b0, 8);
    // Mode together with up, then up together with down
    seg(1'b1, 1'b1, 1'b0, 10);
    seg(1'b0, 1'b0, 1'b0, 10);
    seg(1'b0, 1'b1, 1'b1, 10);
    seg(1'b0, 1'b0, 1'b0, 10);
    // Back to RUN
    press_mode();
    seg(1'b0, 1'b0, 1'b0, 25);

    // Reset while a minute step pulse is high
    press_mode();
    press_mode();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      seen = e_min;
    end
    check("min_pulse_reached", 8'(seen), 8'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    #1 compare_all();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    seg(1'b0, 1'b1, 1'b0, 10);
    seg(1'b0, 1'b0, 1'b0, 15);

    // Long hold in ADJ_MIN (repeat behaviour when enabled)
    press_mode();
    press_mode();
    seg(1'b0, 1'b1, 1'b0, 60);
    seg(1'b0, 1'b0, 1'b0, 10);
    seg(1'b0, 1'b0, 1'b1, 40);
    seg(1'b0, 1'b1, 1'b1, 20);
    seg(1'b0, 1'b0, 1'b0, 10);

    // Randomised hold patterns with occasional resets
    for (int s = 0; s < 350; s++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        repeat ($urandom_range(1, 3)) cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      end else if (sel < 40) begin
        seg(1'b0, 1'b0, 1'b0, $urandom_range(1, 14));
      end else if (sel < 55) begin
        seg(1'b1, 1'b0, 1'b0, $urandom_range(1, 10));
      end else if (sel < 75) begin
        seg(1'b0, 1'b1, 1'b0, $urandom_range(1, 30));
      end else if (sel < 92) begin
        seg(1'b0, 1'b0, 1'b1, $urandom_range(1, 30));
      end else begin
        seg(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 12));
      end
    end

    @(negedge clk);
    compare_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
